// File: rtl/simd_thread_sequencer.sv
`default_nettype none
// ============================================================================
// Module : simd_thread_sequencer
// Issues one active thread per cycle (lowest index first) to the thread
// register file and tracks each one through the execute pipe to writeback.
// Rev    : 1.0
// ============================================================================
module simd_thread_sequencer #(
    parameter int NUM_THREADS = 16,
    parameter int PIPE_DEPTH  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_THREADS-1:0] thread_mask,
    input  logic                   stall,
    output logic [4:0]             thread_read,
    output logic                   issue_valid,
    output logic [4:0]             thread_write,
    output logic                   wb_valid,
    output logic [31:0]            tidx,
    output logic                   busy,
    output logic                   done
);

    localparam logic [NUM_THREADS-1:0] MASK_ONE = NUM_THREADS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_THREADS-1:0] pending_q, pending_d;
    logic [PIPE_DEPTH-1:0]  pipe_vld_q, pipe_vld_d;
    logic [4:0]             pipe_id_q [PIPE_DEPTH];
    logic [4:0]             pipe_id_d [PIPE_DEPTH];
    logic                   done_q, done_d;
    logic [4:0]             lowest_id;
    logic [NUM_THREADS-1:0] pending_clr;

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        lowest_id = 5'd0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest_id = 5'(i);
            end
        end
    end

    assign pending_clr = pending_q & (pending_q - MASK_ONE);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        pipe_vld_d  = pipe_vld_q;
        pipe_id_d   = pipe_id_q;
        done_d      = 1'b0;
        issue_valid = (state_q == S_ISSUE) && !stall;
        thread_read = issue_valid ? lowest_id : 5'd0;

        if (!stall) begin
            pipe_vld_d = (pipe_vld_q << 1) | PIPE_DEPTH'(issue_valid);
            for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
                pipe_id_d[i] = pipe_id_q[i-1];
            end
            pipe_id_d[0] = thread_read;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (|thread_mask) begin
                        pending_d = thread_mask;
                        state_d   = S_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_valid) begin
                    pending_d = pending_clr;
                    if (pending_clr == '0) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave one cycle early so done and the IDLE return coincide.
                if (pipe_vld_d == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            pipe_vld_q <= '0;
            pipe_id_q  <= '{default: 5'd0};
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_id_q  <= pipe_id_d;
            done_q     <= done_d;
        end
    end

    assign wb_valid     = pipe_vld_q[PIPE_DEPTH-1];
    assign thread_write = wb_valid ? pipe_id_q[PIPE_DEPTH-1] : 5'd0;
    assign tidx         = {27'd0, thread_read};
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_simd_thread_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_simd_thread_sequencer
// Scoreboard bench: stimulus queues expected issues/done times, a negedge
// monitor matches the DUT outputs against them.
// Rev    : 1.0
// ============================================================================
module tb_simd_thread_sequencer;

    localparam int NT = 16;
    localparam int PD = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NT-1:0] thread_mask = '0;
    logic          stall = 1'b0;
    logic [4:0]    thread_read;
    logic          issue_valid;
    logic [4:0]    thread_write;
    logic          wb_valid;
    logic [31:0]   tidx;
    logic          busy;
    logic          done;

    simd_thread_sequencer #(.NUM_THREADS(NT), .PIPE_DEPTH(PD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .thread_mask  (thread_mask),
        .stall        (stall),
        .thread_read  (thread_read),
        .issue_valid  (issue_valid),
        .thread_write (thread_write),
        .wb_valid     (wb_valid),
        .tidx         (tidx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] id; int min_cyc; bit last; } iss_t;
    typedef struct { logic [4:0] id; int u; bit last; } wb_t;

    iss_t exp_iss_q[$];
    wb_t  exp_wb_q[$];
    int   exp_done_q[$];
    int   cyc = 0;
    int   ustep = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_done_cyc = -1;
    bit   model_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic bit idle_now();
        return !model_busy || (exp_done_q.size() > 0 && exp_done_q[0] == cyc);
    endfunction

    // Monitor: ustep counts unstalled cycles, so a thread's writeback is due
    // once exactly PD pipeline advances have happened since its issue.
    always @(negedge clk) begin
        bit   iss_exp;
        bit   wb_exp;
        bit   done_exp;
        iss_t ie;
        wb_t  we;
        if (!rst_n) begin
            chk({issue_valid, wb_valid, busy, done, thread_read, thread_write} == '0 && tidx == 0,
                "reset_outputs", {issue_valid, wb_valid, busy, done, thread_read, thread_write}, 0);
        end else begin
            iss_exp = exp_iss_q.size() > 0 && cyc >= exp_iss_q[0].min_cyc && !stall;
            chk(issue_valid == iss_exp, "issue_valid", issue_valid, iss_exp);
            if (iss_exp) begin
                ie = exp_iss_q[0];
                chk(thread_read == ie.id, "thread_read", thread_read, ie.id);
                chk(tidx == {27'd0, ie.id}, "tidx", tidx, ie.id);
                if (issue_valid) begin
                    void'(exp_iss_q.pop_front());
                    we.id = ie.id; we.u = ustep; we.last = ie.last;
                    exp_wb_q.push_back(we);
                end
            end else begin
                chk(thread_read == 0 && tidx == 0, "read_zero", {thread_read, tidx}, 0);
            end

            wb_exp = exp_wb_q.size() > 0 && (ustep - exp_wb_q[0].u) == PD;
            chk(wb_valid == wb_exp, "wb_valid", wb_valid, wb_exp);
            chk(thread_write == (wb_exp ? exp_wb_q[0].id : 5'd0), "thread_write",
                thread_write, wb_exp ? exp_wb_q[0].id : 5'd0);
            if (wb_exp && wb_valid && !stall) begin
                we = exp_wb_q.pop_front();
                if (we.last) exp_done_q.push_back(cyc + 1);
            end

            done_exp = exp_done_q.size() > 0 && exp_done_q[0] == cyc;
            if (done_exp) begin
                void'(exp_done_q.pop_front());
                model_busy = 1'b0;
            end
            chk(done == done_exp, "done", done, done_exp);
            chk(busy == model_busy, "busy", busy, model_busy);
            if (done) last_done_cyc = cyc;
            if (!stall) ustep++;
        end
    end

    // Drives one cycle of inputs, records what the sequencer must do, advances.
    task automatic step(input bit st, input logic [NT-1:0] m, input bit stl);
        bit   acc;
        int   hi;
        iss_t e;
        acc = 1'b0;
        hi  = 0;
        start = st; thread_mask = m; stall = stl;
        if (st && idle_now()) begin
            if (m == '0) begin
                exp_done_q.push_back(cyc + 1);
            end else begin
                acc = 1'b1;
                for (int i = 0; i < NT; i++) if (m[i]) hi = i;
                for (int i = 0; i < NT; i++) begin
                    if (m[i]) begin
                        e.id = 5'(i); e.min_cyc = cyc + 1; e.last = (i == hi);
                        exp_iss_q.push_back(e);
                    end
                end
            end
        end
        @(posedge clk); #1;
        if (acc) model_busy = 1'b1;
        start = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; thread_mask = '0;
        exp_iss_q.delete(); exp_wb_q.delete(); exp_done_q.delete();
        model_busy = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((model_busy || exp_done_q.size() > 0 || exp_iss_q.size() > 0) && n < 200) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        chk(n < 200, "idle_timeout", n, 200);
    endtask

    initial begin
        int t0;
        int saved;
        int n;
        logic [NT-1:0] m;
        do_reset(3);

        t0 = cyc; step(1'b1, 16'h0005, 1'b0); wait_idle();
        chk(last_done_cyc - t0 == 6, "done_cycle_0005", last_done_cyc - t0, 6);

        t0 = cyc; step(1'b1, 16'hFFFF, 1'b0); wait_idle();
        chk(last_done_cyc - t0 == 20, "done_cycle_ffff", last_done_cyc - t0, 20);

        t0 = cyc;
        step(1'b1, 16'h8001, 1'b0); step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);       step(1'b0, '0, 1'b1);
        wait_idle();
        chk(last_done_cyc - t0 == 8, "done_cycle_8001", last_done_cyc - t0, 8);

        t0 = cyc; step(1'b1, '0, 1'b0); wait_idle();
        chk(last_done_cyc - t0 == 1, "done_cycle_zero", last_done_cyc - t0, 1);

        step(1'b1, 16'h0003, 1'b0); step(1'b0, '0, 1'b0); step(1'b1, 16'h0F00, 1'b0);
        wait_idle();

        saved = last_done_cyc;
        step(1'b1, 16'h00FF, 1'b0); step(1'b0, '0, 1'b0); step(1'b0, '0, 1'b0);
        do_reset(1);
        repeat (6) step(1'b0, '0, 1'b0);
        chk(last_done_cyc == saved, "no_done_after_reset", last_done_cyc, saved);
        step(1'b1, 16'h00FF, 1'b0); wait_idle();

        step(1'b1, 16'h0004, 1'b0);
        n = 0;
        while (!(model_busy && exp_done_q.size() > 0 && exp_done_q[0] == cyc) && n < 50) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        chk(n < 50, "b2b_timeout", n, 50);
        step(1'b1, 16'h0002, 1'b0);
        wait_idle();

        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0:       m = '0;
                1:       m = NT'(1) << $urandom_range(0, NT - 1);
                default: m = NT'($urandom);
            endcase
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1);
            end else begin
                step($urandom_range(0, 5) == 0, m, $urandom_range(0, 3) == 0);
            end
        end
        wait_idle();

        chk(exp_iss_q.size() == 0 && exp_wb_q.size() == 0, "queues_empty",
            exp_iss_q.size() + exp_wb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
